// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable clock divider and tick generator.
// Produces a 50%-duty divided level (div_clk) and a one-cycle strobe (tick)
// at every half-period boundary. New half-periods are staged in a shadow
// register and only take effect at a phase boundary, so no runt phase occurs.
// Optional feature macro: CLK_DIV_RESTART_EN adds the 'restart' input, which
// forces an immediate phase restart.
module clk_div_gen #(
    parameter int WIDTH        = 27,
    parameter int DEFAULT_HALF = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_clk,
    output logic             tick,
    output logic             pending,
    output logic             cfg_err
`ifdef CLK_DIV_RESTART_EN
    ,
    input  logic             restart
`endif
);

    localparam logic [WIDTH-1:0] DEFAULT_HALF_C = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] ONE_C          = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C         = {WIDTH{1'b0}};

    // Architectural state
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] half_r;
    logic [WIDTH-1:0] pend_val_r;
    logic             pend_valid_r;
    logic             div_clk_r;
    logic             tick_r;
    logic             cfg_err_r;

    // Next-state values
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] half_nxt_s;
    logic [WIDTH-1:0] pend_val_nxt_s;
    logic             pend_valid_nxt_s;
    logic             div_clk_nxt_s;
    logic             tick_nxt_s;
    logic             cfg_err_nxt_s;

    logic             restart_s;
    logic             terminal_s;

`ifdef CLK_DIV_RESTART_EN
    assign restart_s = restart;
`else
    assign restart_s = 1'b0;
`endif

    // Last cycle of the current half-period; half_r of 1 makes every cycle terminal.
    assign terminal_s = (count_r == (half_r - ONE_C));

    // Next-state: phase restart, counting/terminal handling, then shadow load.
    always_comb begin
        count_nxt_s      = count_r;
        half_nxt_s       = half_r;
        pend_val_nxt_s   = pend_val_r;
        pend_valid_nxt_s = pend_valid_r;
        div_clk_nxt_s    = div_clk_r;
        tick_nxt_s       = 1'b0;
        cfg_err_nxt_s    = 1'b0;

        if (restart_s) begin
            // Restart outranks enable and terminal handling; a pending value
            // is adopted immediately since this is a phase boundary too.
            count_nxt_s   = ZERO_C;
            div_clk_nxt_s = 1'b0;
            if (pend_valid_r) begin
                half_nxt_s       = pend_val_r;
                pend_valid_nxt_s = 1'b0;
            end else begin
                half_nxt_s       = half_r;
            end
        end else if (en) begin
            if (terminal_s) begin
                count_nxt_s   = ZERO_C;
                div_clk_nxt_s = ~div_clk_r;
                tick_nxt_s    = 1'b1;
                if (pend_valid_r) begin
                    half_nxt_s       = pend_val_r;
                    pend_valid_nxt_s = 1'b0;
                end else begin
                    half_nxt_s       = half_r;
                end
            end else begin
                count_nxt_s = count_r + ONE_C;
            end
        end else begin
            // Disabled: counter and level freeze, tick stays low.
            count_nxt_s = count_r;
        end

        // Load is evaluated after the apply so a load on a terminal edge
        // re-arms the shadow with the new value for the following boundary.
        if (div_load) begin
            if (div_in != ZERO_C) begin
                pend_val_nxt_s   = div_in;
                pend_valid_nxt_s = 1'b1;
            end else begin
                cfg_err_nxt_s    = 1'b1;
            end
        end else begin
            cfg_err_nxt_s = 1'b0;
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= ZERO_C;
            half_r       <= DEFAULT_HALF_C;
            pend_val_r   <= ZERO_C;
            pend_valid_r <= 1'b0;
            div_clk_r    <= 1'b0;
            tick_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            half_r       <= half_nxt_s;
            pend_val_r   <= pend_val_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            div_clk_r    <= div_clk_nxt_s;
            tick_r       <= tick_nxt_s;
            cfg_err_r    <= cfg_err_nxt_s;
        end
    end

    assign div_clk = div_clk_r;
    assign tick    = tick_r;
    assign pending = pend_valid_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen (WIDTH=8, DEFAULT_HALF=3).
// Directed scenarios plus a randomized run, compared cycle by cycle against
// a phase-level behavioural model. Restart checks exist when
// CLK_DIV_RESTART_EN is defined.
module tb_clk_div_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       restart;
    logic       div_clk;
    logic       tick;
    logic       pending;
    logic       cfg_err;

    int n_pass;
    int n_total;

    // Behavioural model: cycles elapsed in the current phase, phase length,
    // output level and staged configuration.
    int m_elapsed;
    int m_half;
    int m_pend_val;
    bit m_pend;
    bit m_level;
    bit m_tick;
    bit m_err;

    clk_div_gen #(
        .WIDTH        (8),
        .DEFAULT_HALF (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_clk  (div_clk),
        .tick     (tick),
        .pending  (pending),
        .cfg_err  (cfg_err)
`ifdef CLK_DIV_RESTART_EN
        ,
        .restart  (restart)
`endif
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total = n_total + 1;
        assert (obs == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge given the inputs seen at that edge.
    task automatic model_edge(input bit r, input bit e, input bit ld, input int d, input bit rs);
        if (r) begin
            m_elapsed = 0;
            m_half    = 3;
            m_pend    = 1'b0;
            m_level   = 1'b0;
            m_tick    = 1'b0;
            m_err     = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_err  = 1'b0;
            if (rs) begin
                m_elapsed = 0;
                m_level   = 1'b0;
                if (m_pend) begin
                    m_half = m_pend_val;
                    m_pend = 1'b0;
                end
            end else if (e) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_half) begin
                    m_elapsed = 0;
                    m_level   = ~m_level;
                    m_tick    = 1'b1;
                    if (m_pend) begin
                        m_half = m_pend_val;
                        m_pend = 1'b0;
                    end
                end
            end
            if (ld) begin
                if (d != 0) begin
                    m_pend_val = d;
                    m_pend     = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare all outputs to the model.
    task automatic step(input bit r, input bit e, input bit ld, input int d, input bit rs);
        rst      = r;
        en       = e;
        div_load = ld;
        div_in   = 8'(d);
        restart  = rs;
        @(posedge clk);
        model_edge(r, e, ld, d, rs);
        #1;
        check("div_clk", div_clk, m_level);
        check("tick",    tick,    m_tick);
        check("pending", pending, m_pend);
        check("cfg_err", cfg_err, m_err);
    endtask

    // Count enabled cycles up to and including the next tick (called at a boundary).
    task automatic measure(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b0);
            n = n + 1;
        end while (tick !== 1'b1 && n < 300);
        if (n >= 300) check("measure_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        n_pass     = 0;
        n_total    = 0;
        m_pend_val = 0;
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = 8'd0; restart = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("rst_div_clk", div_clk, 1'b0);
        check("rst_pending", pending, 1'b0);

        // Default divide by 6: toggles after edges 3, 6, 9, 12
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b0);
            check("s1_level", div_clk, ((k / 3) % 2) == 1);
            check("s1_tick",  tick,    (k % 3) == 0);
        end

        // Load 5 at count 1: current phase still 3, following phases 5
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5, 1'b0);
        check("s2_pending", pending, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("s2_tick_old_phase", tick, 1'b1);
        check("s2_pending_clear", pending, 1'b0);
        measure(n); check_int("s2_phase5a", n, 5);
        measure(n); check_int("s2_phase5b", n, 5);

        // Zero load rejected: one-cycle cfg_err, period unchanged
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0);
        check("s3_cfg_err", cfg_err, 1'b1);
        check("s3_pending", pending, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("s3_cfg_err_drop", cfg_err, 1'b0);
        measure(n); check_int("s3_phase", n, 1);
        measure(n); check_int("s3_phase3", n, 3);

        // Enable low for 4 cycles at count 1 stretches the phase to 7
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        n = 5;
        do begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b0);
            n = n + 1;
        end while (tick !== 1'b1 && n < 300);
        check_int("s4_stretched", n, 7);
        measure(n); check_int("s4_phase3", n, 3);

        // Load 4 on a terminal edge while 2 is pending
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        measure(n); check_int("s5_first", n, 3);
        step(1'b0, 1'b1, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4, 1'b0);
        check("s5_term_tick", tick, 1'b1);
        check("s5_pend_held", pending, 1'b1);
        measure(n); check_int("s5_phase2", n, 2);
        measure(n); check_int("s5_phase4", n, 4);
        // Reset mid-phase
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 7, 1'b0);
        check("s5_rst_div_clk", div_clk, 1'b0);
        check("s5_rst_tick",    tick,    1'b0);
        check("s5_rst_pending", pending, 1'b0);
        measure(n); check_int("s5_after_rst", n, 3);

`ifdef CLK_DIV_RESTART_EN
        // Restart at count 2 with div_clk high
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        measure(n);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("r_level_before", div_clk, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1);
        check("r_level_after", div_clk, 1'b0);
        measure(n); check_int("r_phase", n, 3);
        // Restart with a pending value adopts it immediately
        step(1'b0, 1'b1, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6, 1'b1);
        check("r_pend_rearmed", pending, 1'b1);
        measure(n); check_int("r_phase2", n, 2);
`endif

        // Randomized traffic against the model
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 600; k++) begin
            bit r_r, e_r, ld_r, rs_r;
            int d_r;
            r_r  = ($urandom_range(0, 63) == 0);
            e_r  = ($urandom_range(0, 7) != 0);
            ld_r = ($urandom_range(0, 5) == 0);
            d_r  = $urandom_range(0, 6);
`ifdef CLK_DIV_RESTART_EN
            rs_r = ($urandom_range(0, 31) == 0);
`else
            rs_r = 1'b0;
`endif
            step(r_r, e_r, ld_r, d_r, rs_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised, runtime-programmable clock divider and enable-pulse generator. It is the successor to the fixed-ratio toggle divider. It produces a 50%-duty divided level (`div_clk`) and a one-cycle strobe (`tick`) at every half-period boundary from the single system clock. It sits between the board clock and slow logic such as LFSRs, display scanners and debouncers. Downstream logic should prefer `tick` as a clock enable over using `div_clk` as a clock.

## Interface
Parameters:
- `WIDTH`, 27, width of the counter and of the half-period value.
- `DEFAULT_HALF`, 100000000, half-period in clk cycles loaded at reset. Legal range is 1 .. 2^WIDTH-1.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; low freezes the divider.
- `div_in`  in  WIDTH  requested half-period, in cycles.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_clk`  out  1  divided clock level, registered.
- `tick`  out  1  one-cycle pulse on each `div_clk` edge, registered.
- `pending`  out  1  a loaded value is waiting to take effect.
- `cfg_err`  out  1  one-cycle pulse when a load of zero is rejected.
- `restart`  in  1  only present with `CLK_DIV_RESTART_EN`; immediate phase restart.

## Operation
- Internal state:
  - `count[WIDTH-1:0]`
  - active half-period `half_q`
  - shadow `pend_val`
  - `pend_valid` (drives `pending`)
- Reset (`rst` high at an edge): `count`=0, `half_q`=`DEFAULT_HALF`, `pend_valid`=0, `div_clk`=0, `tick`=0, `cfg_err`=0. Reset overrides every other input.
- Counting, when `en`=1:
  - A cycle is terminal when `count == half_q-1`.
  - On a terminal edge: `count`<=0, `div_clk`<=~`div_clk`, `tick`<=1.
  - On any other edge: `count`<=`count`+1, `tick`<=0.
- Counting, when `en`=0: `count` and `div_clk` hold and `tick`<=0. Loads are still accepted while disabled.
- Load with `div_load`=1 and `div_in`!=0: `pend_val`<=`div_in`, `pend_valid`<=1. When several loads arrive before a terminal, the last one wins.
- Load with `div_load`=1 and `div_in`==0: the load is rejected. `cfg_err`<=1 for one cycle. `pend_val`, `pend_valid` and `half_q` are unchanged.
- Apply: on a terminal edge with `pend_valid`=1, `half_q`<=`pend_val` and `pend_valid`<=0. The change only ever happens at a phase boundary, so no runt phase is produced.
- Load on the same edge as a terminal: any already-pending value is applied on that edge. The new `div_in` is captured into `pend_val` with `pend_valid` held at 1, and is applied at the next terminal.
- Arithmetic: the terminal compare uses `half_q-1` in WIDTH bits, so `half_q`=1 toggles every cycle. The counter never exceeds `half_q-1` and has no wrap beyond it.
- The full output period is 2×`half_q` cycles. The low and high phases are exactly equal.

## Timing
- All outputs are registered, with no combinational path from input to output.
- The first edge with `rst` low is edge 1. With `en` held high, `div_clk` first rises after edge `half_q`. `tick` is high during the cycle after edges `half_q`, 2·`half_q`, and so on.
- `pending` rises on the edge after an accepted load. It falls on the edge that applies the value.
- `cfg_err` is high for exactly the one cycle following the rejecting edge.
- Deasserting `en` for k cycles mid-phase stretches that phase by exactly k cycles.
- Reset mid-phase: on the next edge all outputs go to their reset values and any pending value is discarded.

## Configuration
- `CLK_DIV_RESTART_EN` defined:
  - The `restart` port exists.
  - `restart`=1 at an edge, with `rst`=0: `count`<=0, `div_clk`<=0, `tick`<=0.
  - If `pend_valid`=1, `half_q`<=`pend_val` and `pend_valid`<=0 on that same edge.
  - `restart` takes priority over `en` and over terminal handling. A simultaneous `div_load` is still processed into the shadow.
- `CLK_DIV_RESTART_EN` undefined: the port is absent and the phase can be reset only by `rst`.

## Test plan
All scenarios use `WIDTH`=8 and `DEFAULT_HALF`=3.
- Reset, then `en`=1 -> `div_clk` toggles after edges 3, 6, 9 (period 6); `tick` is high for one cycle after each; `pending`=0.
- At `count`=1, load `div_in`=5 -> `pending`=1 from the next cycle; the current phase still ends at 3 cycles; the following phases are 5 cycles; `pending` clears on the applying edge.
- Load `div_in`=0 -> `cfg_err` is high for exactly one cycle; the period stays 6; `pending` is unchanged.
- `en` low for 4 cycles at `count`=1 -> that phase lasts 7 cycles with no `tick` meanwhile; later phases are 3 cycles.
- Load 4 on a terminal edge while 2 is pending -> the next phase is 2 cycles, then phases of 4; `rst` asserted mid-phase -> next edge shows `div_clk`=0, `tick`=0, `pending`=0, and counting resumes with `half_q`=3.
- With `CLK_DIV_RESTART_EN`, `restart` at `count`=2 with `div_clk`=1 -> next edge shows `div_clk`=0 and `count`=0, and the next toggle comes 3 cycles later.
